// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter in front of a single shared N-bit adder.
// A granted request is latched, then summed in one (narrow) or two/three
// (wide, with a carry-propagation increment) passes through the same adder.
// The result is presented from registers until the consumer accepts it.
module adder_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_wide,
  input  logic [NREQ*2*N-1:0]       req_a,
  input  logic [NREQ*2*N-1:0]       req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*N-1:0]            rsp_sum,
  output logic                      rsp_cout,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, LO, HI, INC, DONE} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   last_grant_reg;
  logic [IDW-1:0]   id_reg;
  logic [2*N-1:0]   a_reg;
  logic [2*N-1:0]   b_reg;
  logic             wide_reg;
  logic [N-1:0]     sum_lo_reg;
  logic [N-1:0]     sum_hi_reg;
  logic             c_lo_reg;
  logic             c_hi_reg;

  logic [2*N-1:0]   a_arr [NREQ];
  logic [2*N-1:0]   b_arr [NREQ];
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic             grant_en;
  logic             accept;
  logic [N-1:0]     add_x;
  logic [N-1:0]     add_y;
  logic [N:0]       add_full;

  // Offers are only made in IDLE and never while reset is held, so the
  // ready vector is silent during reset even though it is combinational.
  assign grant_en = reset_n && (state_reg == IDLE) && win_found;
  assign accept   = |(req_valid & req_ready);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign a_arr[gi]     = req_a[gi*2*N +: 2*N];
      assign b_arr[gi]     = req_b[gi*2*N +: 2*N];
      assign req_ready[gi] = grant_en && (win_idx == IDW'(gi));
    end
  endgenerate

  // Round-robin pick: scan offsets from far to near so the nearest valid
  // requester after last_grant overwrites any farther candidate.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = IDW'((int'(last_grant_reg) + off) % NREQ);
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Operand steering for the one shared adder; INC reuses it as an incrementer.
  always_comb begin
    add_x = '0;
    add_y = '0;
    case (state_reg)
      LO: begin
        add_x = a_reg[N-1:0];
        add_y = b_reg[N-1:0];
      end
      HI: begin
        add_x = a_reg[2*N-1:N];
        add_y = b_reg[2*N-1:N];
      end
      INC: begin
        add_x = sum_hi_reg;
        add_y = N'(1);
      end
      default: ;
    endcase
  end

  assign add_full = {1'b0, add_x} + {1'b0, add_y};

  // Control FSM and datapath registers: capture on accept, one adder pass per state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDW'(NREQ - 1);
      id_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      wide_reg       <= 1'b0;
      sum_lo_reg     <= '0;
      sum_hi_reg     <= '0;
      c_lo_reg       <= 1'b0;
      c_hi_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg          <= a_arr[win_idx];
            b_reg          <= b_arr[win_idx];
            wide_reg       <= req_wide[win_idx];
            id_reg         <= win_idx;
            last_grant_reg <= win_idx;
            state_reg      <= LO;
          end
        end
        LO: begin
          sum_lo_reg <= add_full[N-1:0];
          c_lo_reg   <= add_full[N];
          state_reg  <= wide_reg ? HI : DONE;
        end
        HI: begin
          sum_hi_reg <= add_full[N-1:0];
          c_hi_reg   <= add_full[N];
          state_reg  <= c_lo_reg ? INC : DONE;
        end
        INC: begin
          sum_hi_reg <= add_full[N-1:0];
          c_hi_reg   <= c_hi_reg | add_full[N];
          state_reg  <= DONE;
        end
        DONE: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Response fields are pure selections of held registers, stable through DONE.
  assign rsp_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign rsp_id    = id_reg;
  assign rsp_sum   = wide_reg ? {sum_hi_reg, sum_lo_reg} : {{N{1'b0}}, sum_lo_reg};
  assign rsp_cout  = wide_reg ? c_hi_reg : c_lo_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scenarios plus a randomized phase, all checked
// cycle by cycle against a transaction-level reference model.
module tb_adder_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [3:0]   req_wide;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  logic         rsp_cout;
  logic         busy;

  adder_arbiter #(.N(16), .NREQ(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wide(req_wide),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: one outstanding transaction at most.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 0;
  logic [1:0]  m_id = 2'd0;
  logic [1:0]  m_last = 2'd3;
  logic [31:0] m_sum = '0;
  logic        m_cout = 1'b0;
  logic        seen_valid = 1'b0;
  logic        last_valid = 1'b0;
  int          first_lat = 0;
  int          rsp_count = 0;
  logic [31:0] obs_sum = '0;
  logic        obs_cout = 1'b0;
  logic [1:0]  obs_id = 2'd0;
  int          grant_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next owner: first valid index after the last grant, wrapping.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(last) + k) % 4;
      if (v[idx]) return 2'(idx);
    end
    return 2'd0;
  endfunction

  // One clock cycle: drive at the falling edge, check, advance to next falling edge.
  task automatic step(input logic [3:0] v, input logic rdy);
    logic [1:0]  p;
    logic [31:0] a, b;
    logic [16:0] lo;
    logic [32:0] full;
    if (m_busy) begin
      // Operands must be ignored once the request is captured.
      req_a    = {$urandom, $urandom, $urandom, $urandom};
      req_b    = {$urandom, $urandom, $urandom, $urandom};
      req_wide = 4'($urandom);
    end
    req_valid = v;
    rsp_ready = rdy;
    #1;
    check("ready_onehot0", 64'($countones(req_ready) <= 1), 64'd1);
    last_valid = 1'b0;
    if (!m_busy) begin
      check("idle_busy", busy, 0);
      check("idle_rsp_valid", rsp_valid, 0);
      if (v != 4'd0) begin
        p = rr_pick(v, m_last);
        check("grant", req_ready, 4'b0001 << p);
        a  = req_a[p*32 +: 32];
        b  = req_b[p*32 +: 32];
        lo = {1'b0, a[15:0]} + {1'b0, b[15:0]};
        if (req_wide[p]) begin
          full   = {1'b0, a} + {1'b0, b};
          m_sum  = full[31:0];
          m_cout = full[32];
          m_lat  = lo[16] ? 4 : 3;
        end else begin
          m_sum  = {16'h0, lo[15:0]};
          m_cout = lo[16];
          m_lat  = 2;
        end
        m_id = p; m_last = p; m_busy = 1'b1; m_cnt = 0; seen_valid = 1'b0;
        grant_q.push_back(int'(p));
        $display("grant id=%0d a=%h b=%h wide=%0d", p, a, b, req_wide[p]);
      end else begin
        check("no_grant", req_ready, 0);
      end
    end else begin
      m_cnt++;
      check("busy_ready", req_ready, 0);
      check("busy_flag", busy, 1);
      check("rsp_valid", rsp_valid, m_cnt >= m_lat);
      if (rsp_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_lat  = m_cnt;
      end
      if (m_cnt >= m_lat) begin
        last_valid = 1'b1;
        check("rsp_sum", rsp_sum, m_sum);
        check("rsp_cout", rsp_cout, m_cout);
        check("rsp_id", rsp_id, m_id);
        if (rdy) begin
          m_busy = 1'b0;
          rsp_count++;
          obs_sum = rsp_sum; obs_cout = rsp_cout; obs_id = rsp_id;
          $display("rsp id=%0d sum=%h cout=%0d", rsp_id, rsp_sum, rsp_cout);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_rsp(input string tag, input logic [3:0] v_idle,
                               input logic [3:0] v_busy, input int stall);
    int start, n, stalled;
    start = rsp_count; n = 0; stalled = 0;
    while (rsp_count == start && n < 40) begin
      step(m_busy ? v_busy : v_idle, stalled >= stall);
      if (last_valid && rsp_count == start) stalled++;
      n++;
    end
    check({tag, "_done"}, rsp_count, start + 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_busy && n < 40) begin
      step(4'd0, 1'b1);
      n++;
    end
    check("drain", m_busy, 0);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic w);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_wide[i]       = w;
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n;
    reset_n   = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    req_wide  = 4'h0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Fairness: everyone requests continuously from reset release.
    n = 0;
    while (grant_q.size() < 5 && n < 60) begin
      step(4'hF, 1'b1);
      n++;
    end
    check("fair_count", grant_q.size(), 5);
    for (int i = 0; i < 5 && i < grant_q.size(); i++)
      check("fair_order", grant_q[i], exp_order[i]);
    drain();

    // Narrow add with carry out.
    set_op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    run_until_rsp("narrow", 4'b0010, 4'b0010, 0);
    check("narrow_sum", obs_sum, 32'h0);
    check("narrow_cout", obs_cout, 1);
    check("narrow_id", obs_id, 1);
    check("narrow_lat", first_lat, 2);

    // Wide add that needs the increment pass.
    set_op(0, 32'h0000_FFFF, 32'h0000_0001, 1'b1);
    run_until_rsp("wide_inc", 4'b0001, 4'b0000, 0);
    check("wide_inc_sum", obs_sum, 32'h0001_0000);
    check("wide_inc_cout", obs_cout, 0);
    check("wide_inc_lat", first_lat, 4);

    // Wide overflow through the increment pass.
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    run_until_rsp("wide_ovf", 4'b0100, 4'b0000, 0);
    check("wide_ovf_sum", obs_sum, 32'h0);
    check("wide_ovf_cout", obs_cout, 1);

    // Wide overflow from the high half only.
    set_op(3, 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_until_rsp("wide_hi", 4'b1000, 4'b0000, 0);
    check("wide_hi_sum", obs_sum, 32'h0);
    check("wide_hi_cout", obs_cout, 1);
    check("wide_hi_lat", first_lat, 3);
    check("wide_hi_id", obs_id, 3);

    // Backpressure: five stalled cycles in DONE with everyone requesting.
    set_op(1, 32'h0000_1234, 32'h0000_4321, 1'b0);
    run_until_rsp("stall", 4'b0010, 4'hF, 5);
    check("stall_sum", obs_sum, 32'h0000_5555);
    step(4'h0, 1'b1);

    // Reset in the middle of a wide operation (while in HI).
    set_op(2, 32'h0001_FFFF, 32'h0001_0001, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    req_valid = 4'hF;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_sum", rsp_sum, 0);
    check("midrst_rsp_id", rsp_id, 0);
    check("midrst_rsp_cout", rsp_cout, 0);
    check("midrst_req_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_busy = 1'b0;
    m_last = 2'd3;
    grant_q.delete();
    run_until_rsp("postrst", 4'hF, 4'hF, 0);
    check("postrst_first", grant_q.size() > 0 ? grant_q[0] : 99, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (!m_busy) begin
        req_a    = {$urandom, $urandom, $urandom, $urandom};
        req_b    = {$urandom, $urandom, $urandom, $urandom};
        req_wide = 4'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          for (int k = 0; k < 4; k++) req_a[k*32 +: 16] = 16'hFFFF;
        end
      end
      step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
